// File: rtl/regfile_stack_pkg.sv
// ============================================================================
// Package : RegFilePkg
// Brief   : Shared command encoding and sizing constants for regfile_stack.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package RegFilePkg;

  typedef enum logic [1:0] {
    none = 2'd0,
    push = 2'd1,
    pop  = 2'd2
  } Command;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  // Flattened width of one bank's registers r1..r31 (r0 is not stored).
  localparam int ALL_W     = (REG_COUNT - 1) * DATA_W;

endpackage

`default_nettype wire

// File: rtl/regfile_bank.sv
// ============================================================================
// Module : regfile_bank
// Brief  : One context level: 31 x 32-bit registers, full-bank load, one write
//          port, two combinational read ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_bank
  import RegFilePkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [ALL_W-1:0]  i_load_data,
  input  logic              i_w_ena,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_a_data,
  output logic [DATA_W-1:0] o_b_data,
  output logic [ALL_W-1:0]  o_all
);

  logic [DATA_W-1:0] r_regs [1:REG_COUNT-1];

  // A write in the same cycle as a load takes priority for its register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (i_w_ena && (i_w_addr == ADDR_W'(i))) begin
          r_regs[i] <= i_w_data;
        end else if (i_load) begin
          r_regs[i] <= i_load_data[(i-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    o_a_data = '0;
    o_b_data = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (i_a_addr == ADDR_W'(i)) begin
        o_a_data = r_regs[i];
      end
      if (i_b_addr == ADDR_W'(i)) begin
        o_b_data = r_regs[i];
      end
    end
  end

  generate
    for (genvar g = 1; g < REG_COUNT; g++) begin : g_flat
      assign o_all[(g-1)*DATA_W +: DATA_W] = r_regs[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_stack.sv
// ============================================================================
// Module : regfile_stack
// Brief  : 32 x 32-bit register file with a DEPTH-level context stack for fast
//          interrupt entry (push copies current context) and exit (pop).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_stack
  import RegFilePkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_command,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic              i_w_ena,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  output logic [DATA_W-1:0] o_a_data,
  output logic [DATA_W-1:0] o_b_data
);

  localparam int              SP_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] C_SP_MAX = SP_W'(DEPTH - 1);

  logic [SP_W-1:0]   r_sp;
  Command            w_cmd;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_wr_ok;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_wr_level;
  logic [ALL_W-1:0]  w_cur_all;

  logic [DATA_W-1:0] w_a_bank   [DEPTH];
  logic [DATA_W-1:0] w_b_bank   [DEPTH];
  logic [ALL_W-1:0]  w_all_bank [DEPTH];

  assign w_sp_inc = r_sp + SP_W'(1);

  // Unknown command encodings fall through to the default and act as none.
  always_comb begin
    w_cmd      = Command'(i_command);
    w_push_ok  = 1'b0;
    w_pop_ok   = 1'b0;
    w_wr_ok    = i_w_ena && (i_w_addr != '0);
    w_wr_level = r_sp;
    case (w_cmd)
      push: begin
        w_push_ok = (r_sp != C_SP_MAX);
        if (r_sp != C_SP_MAX) begin
          w_wr_level = w_sp_inc;
        end
      end
      pop: begin
        w_pop_ok = (r_sp != '0);
        w_wr_ok  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sp <= '0;
    end else if (w_push_ok) begin
      r_sp <= w_sp_inc;
    end else if (w_pop_ok) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  assign w_cur_all = w_all_bank[r_sp];

  generate
    for (genvar l = 0; l < DEPTH; l++) begin : g_bank
      localparam logic [SP_W-1:0] C_LEVEL = SP_W'(l);
      logic w_load;
      logic w_ena;

      assign w_load = w_push_ok && (w_sp_inc == C_LEVEL);
      assign w_ena  = w_wr_ok && (w_wr_level == C_LEVEL);

      regfile_bank u_bank (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_load_data (w_cur_all),
        .i_w_ena     (w_ena),
        .i_w_addr    (i_w_addr),
        .i_w_data    (i_w_data),
        .i_a_addr    (i_a_addr),
        .i_b_addr    (i_b_addr),
        .o_a_data    (w_a_bank[l]),
        .o_b_data    (w_b_bank[l]),
        .o_all       (w_all_bank[l])
      );
    end
  endgenerate

  assign o_a_data = w_a_bank[r_sp];
  assign o_b_data = w_b_bank[r_sp];

endmodule

`default_nettype wire

// File: tb/tb_regfile_stack.sv
// ============================================================================
// Module : tb_regfile_stack
// Brief  : Directed self-checking bench for regfile_stack (DEPTH = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_stack;
  import RegFilePkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  command;
  logic [4:0]  a_addr;
  logic [4:0]  b_addr;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] a_data;
  logic [31:0] b_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_stack #(.DEPTH(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_command (command),
    .i_a_addr  (a_addr),
    .i_b_addr  (b_addr),
    .i_w_ena   (w_ena),
    .i_w_addr  (w_addr),
    .i_w_data  (w_data),
    .o_a_data  (a_data),
    .o_b_data  (b_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one command/write for a single rising edge, then return to idle.
  task automatic step(input logic [1:0] cmd, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    @(negedge clk);
    command = cmd;
    w_ena   = we;
    w_addr  = wa;
    w_data  = wd;
    @(posedge clk);
    #1;
    command = 2'(none);
    w_ena   = 1'b0;
    w_addr  = '0;
    w_data  = '0;
  endtask

  task automatic rd(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                    input logic [31:0] ea, input logic [31:0] eb);
    a_addr = ra;
    b_addr = rb;
    #1;
    chk({tag, "_a"}, a_data, ea);
    chk({tag, "_b"}, b_data, eb);
  endtask

  initial begin
    rst_n   = 1'b0;
    command = 2'(none);
    a_addr  = 5'd0;
    b_addr  = 5'd0;
    w_ena   = 1'b0;
    w_addr  = 5'd0;
    w_data  = 32'd0;

    // 1. Reset
    repeat (2) @(posedge clk);
    #1;
    rd("in_reset", 5'd5, 5'd31, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rd("post_reset", 5'd1, 5'd31, 32'h0, 32'h0);

    // 2. Basic write/read
    step(2'(none), 1'b1, 5'd1, 32'h100);
    step(2'(none), 1'b1, 5'd2, 32'h1000);
    rd("wr_r1_r2", 5'd1, 5'd2, 32'h100, 32'h1000);
    step(2'(none), 1'b0, 5'd2, 32'h2000);
    rd("wena_low", 5'd2, 5'd1, 32'h1000, 32'h100);
    step(2'(none), 1'b1, 5'd0, 32'h10);
    rd("r0_zero", 5'd0, 5'd1, 32'h0, 32'h100);

    // No bypass: written value appears only after the edge
    @(negedge clk);
    w_ena  = 1'b1;
    w_addr = 5'd3;
    w_data = 32'h33;
    a_addr = 5'd3;
    #1;
    chk("no_bypass", a_data, 32'h0);
    @(posedge clk);
    #1;
    w_ena = 1'b0;
    chk("after_edge", a_data, 32'h33);

    // 3. Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    rd("async_reset", 5'd1, 5'd2, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4. Context stack
    step(2'(none), 1'b1, 5'd1,  32'h1000_0000);
    step(2'(none), 1'b1, 5'd31, 32'h2000_0000);
    rd("base", 5'd1, 5'd31, 32'h1000_0000, 32'h2000_0000);
    step(2'(push), 1'b1, 5'd1, 32'h1000_1000);
    rd("push_wr", 5'd1, 5'd31, 32'h1000_1000, 32'h2000_0000);
    step(2'(none), 1'b1, 5'd31, 32'h2000_2000);
    rd("lvl1_wr", 5'd1, 5'd31, 32'h1000_1000, 32'h2000_2000);
    step(2'(pop), 1'b1, 5'd10, 32'h1010_1010);
    rd("pop_restore", 5'd1, 5'd31, 32'h1000_0000, 32'h2000_0000);
    rd("pop_wr_drop", 5'd10, 5'd0, 32'h0, 32'h0);

    // 5. Overflow: r6 tags each level, r5 written on the overflowing push
    step(2'(push), 1'b1, 5'd6, 32'h61);
    step(2'(push), 1'b1, 5'd6, 32'h62);
    step(2'(push), 1'b1, 5'd6, 32'h63);
    rd("lvl3", 5'd6, 5'd1, 32'h63, 32'h1000_0000);
    step(2'(push), 1'b1, 5'd5, 32'h55);
    rd("overflow", 5'd5, 5'd6, 32'h55, 32'h63);
    step(2'(pop), 1'b0, 5'd0, 32'h0);
    rd("pop_lvl2", 5'd6, 5'd5, 32'h62, 32'h0);
    step(2'(push), 1'b0, 5'd0, 32'h0);
    rd("repush_copy", 5'd6, 5'd5, 32'h62, 32'h0);
    step(2'(pop), 1'b0, 5'd0, 32'h0);
    step(2'(pop), 1'b0, 5'd0, 32'h0);
    rd("pop_lvl1", 5'd6, 5'd31, 32'h61, 32'h2000_0000);
    step(2'(pop), 1'b0, 5'd0, 32'h0);
    rd("pop_base", 5'd6, 5'd1, 32'h0, 32'h1000_0000);

    // 6. Underflow and unknown command encoding
    step(2'(pop), 1'b1, 5'd3, 32'h33);
    rd("underflow", 5'd3, 5'd6, 32'h0, 32'h0);
    step(2'(none), 1'b1, 5'd3, 32'h34);
    rd("after_uflow", 5'd3, 5'd1, 32'h34, 32'h1000_0000);
    step(2'd3, 1'b1, 5'd4, 32'h44);
    rd("cmd3_none", 5'd4, 5'd6, 32'h44, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
